// File: rtl/tagged_arb_pkg.sv
// Shared types and helpers for the tagged round-robin arbiter.
package tagged_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tagged_rr_arbiter_rr_pick.sv
// Round-robin pick: rotate the request vector so ptr lands on bit 0, take the
// lowest set bit, then rotate the chosen offset back into an absolute index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  localparam logic [PW:0] N_V = (PW+1)'(N);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;
  logic          found;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    any   = |rot;
    off   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = PW'(j);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_V) sum = sum - N_V;
    idx = sum[PW-1:0];
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/tagged_rr_arbiter.sv
// Fair arbiter feeding one registered output stage from the inputs tagged ID.
//   state  | meaning
//   IDLE   | re-arbitrate on every element
//   LOCKED | grant pinned to lock_idx until its last element transfers
module tagged_rr_arbiter
  import tagged_arb_pkg::*;
#(
  parameter  int DATA_WIDTH  = 64,
  parameter  int NUM_INPUTS  = 4,
  parameter  int TAG_WIDTH   = 4,
  parameter  int ID          = 0,
  parameter  int FILTER_KEEP = 1,
  parameter  int PACKET_LOCK = 0,
  localparam int SRC_W       = src_width(NUM_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUTS-1:0]           in_valid,
  output logic [NUM_INPUTS-1:0]           in_ready,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0] in_tag,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]           in_keep,
  input  logic [NUM_INPUTS-1:0]           in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_keep,
  output logic                            out_last,
  output logic [SRC_W-1:0]                out_src
);

  logic [NUM_INPUTS-1:0] match, drop, req, gnt;
  logic [SRC_W-1:0]      g;
  logic                  any, can_load;

  arb_state_t            state_q, state_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d, lock_idx_q, lock_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic [SRC_W-1:0]      out_src_q, out_src_d;

  always_comb begin
    can_load = !out_valid_q || out_ready;
    match    = '0;
    drop     = '0;
    req      = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      match[i] = in_valid[i] && (in_tag[i*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(ID));
      // keep=0 with last=1 must still pass so the stream terminates downstream
      drop[i]  = match[i] && (FILTER_KEEP != 0) && !in_keep[i] && !in_last[i];
      req[i]   = match[i] && !drop[i] && can_load;
      if (state_q == LOCKED && SRC_W'(i) != lock_idx_q) req[i] = 1'b0;
    end
  end

  rr_pick #(
    .N  (NUM_INPUTS),
    .PW (SRC_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (g),
    .any (any)
  );

  assign in_ready = drop | gnt;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    if (can_load) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = in_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
        out_keep_d = in_keep[g];
        out_last_d = in_last[g];
        out_src_d  = g;
        ptr_d      = (int'(g) == NUM_INPUTS-1) ? '0 : g + SRC_W'(1);
      end
    end
    if (any && PACKET_LOCK != 0) begin
      if (state_q == IDLE && !in_last[g]) begin
        state_d    = LOCKED;
        lock_idx_d = g;
      end else if (state_q == LOCKED && in_last[g]) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      state_q     <= IDLE;
      lock_idx_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_tagged_rr_arbiter.sv
// Scoreboard bench: dut0 re-arbitrates per element, dut1 locks per packet.
module tb_tagged_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 4;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] data;
    logic        keep;
    logic        last;
  } elem_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] data;
    logic        keep;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1, sel, out_ready;
  logic [N-1:0]    in_valid, in_keep, in_last, in_ready0, in_ready1, rdy, hs;
  logic [N*TW-1:0] in_tag;
  logic [N*DW-1:0] in_data;
  logic            o0_valid, o0_keep, o0_last, o1_valid, o1_keep, o1_last;
  logic [DW-1:0]   o0_data, o1_data;
  logic [1:0]      o0_src, o1_src;

  elem_t src_q[N][$];
  exp_t  exp_q0[$];
  exp_t  exp_q1[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;
  assign rdy = sel ? in_ready1 : in_ready0;

  tagged_rr_arbiter #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .TAG_WIDTH(TW), .ID(2),
                      .FILTER_KEEP(1), .PACKET_LOCK(0)) dut0 (
    .clk(clk), .rst(rst0), .in_valid(in_valid), .in_ready(in_ready0), .in_tag(in_tag),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .out_valid(o0_valid),
    .out_ready(out_ready), .out_data(o0_data), .out_keep(o0_keep), .out_last(o0_last),
    .out_src(o0_src));

  tagged_rr_arbiter #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .TAG_WIDTH(TW), .ID(2),
                      .FILTER_KEEP(1), .PACKET_LOCK(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid), .in_ready(in_ready1), .in_tag(in_tag),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .out_valid(o1_valid),
    .out_ready(out_ready), .out_data(o1_data), .out_keep(o1_keep), .out_last(o1_last),
    .out_src(o1_src));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic put(input int i, input logic [3:0] t, input logic [15:0] d,
                     input logic k, input logic l);
    elem_t e;
    e.tag = t; e.data = d; e.keep = k; e.last = l;
    src_q[i].push_back(e);
  endtask

  task automatic expect_out(input logic [1:0] s, input logic [15:0] d,
                            input logic k, input logic l);
    exp_t e;
    e.src = s; e.data = d; e.keep = k; e.last = l;
    if (sel) exp_q1.push_back(e);
    else     exp_q0.push_back(e);
  endtask

  task automatic drive();
    elem_t e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) e = src_q[i][0];
      else                     e = '0;
      in_valid[i]          = (src_q[i].size() > 0);
      in_tag[i*TW +: TW]   = e.tag;
      in_data[i*DW +: DW]  = e.data;
      in_keep[i]           = e.keep;
      in_last[i]           = e.last;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    hs = in_valid & rdy;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic drain();
    int n = 0;
    while ((sel ? exp_q1.size() : exp_q0.size()) != 0 && n < 30) begin
      cyc();
      n++;
    end
    chk("drain_pending", 32'(sel ? exp_q1.size() : exp_q0.size()), 32'd0);
    cyc();
    cyc();
  endtask

  // Output monitors: pop and compare on every output transfer
  initial forever begin
    @(negedge clk);
    if (!rst0 && o0_valid && out_ready) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected actual=src%0d data %0h required=no output", o0_src, o0_data);
      end else begin
        chk("dut0_out", 32'({o0_src, o0_data, o0_keep, o0_last}), 32'(exp_q0.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst1 && o1_valid && out_ready) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected actual=src%0d data %0h required=no output", o1_src, o1_data);
      end else begin
        chk("dut1_out", 32'({o1_src, o1_data, o1_keep, o1_last}), 32'(exp_q1.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt[N];
    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1; out_ready = 1'b0; hs = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    sample();
    chk("rst0_valid", 32'(o0_valid), 32'd0);
    chk("rst0_src",   32'(o0_src),   32'd0);
    chk("rst0_data",  32'(o0_data),  32'd0);
    advance();

    // all four inputs matching: strict rotation 0,1,2,3,0,1,2,3
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        put(i, 4'd2, 16'(i*256 + k), 1'b1, 1'b1);
        expect_out(2'(i), 16'(i*256 + k), 1'b1, 1'b1);
      end
    drive();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      sample();
      for (int i = 0; i < N; i++) cnt[i] += int'(hs[i]);
      advance();
    end
    for (int i = 0; i < N; i++) chk("t1_ready_count", 32'(cnt[i]), 32'd2);
    chk("t1_left", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 32'd0);
    drain();

    // input1 carries a foreign tag and is never taken
    for (int k = 0; k < 2; k++) begin
      put(0, 4'd2, 16'h2000 + 16'(k), 1'b1, 1'b1);
      put(2, 4'd2, 16'h2200 + 16'(k), 1'b1, 1'b1);
    end
    for (int k = 0; k < 3; k++) put(1, 4'd3, 16'h2100 + 16'(k), 1'b1, 1'b1);
    expect_out(2'd0, 16'h2000, 1'b1, 1'b1);
    expect_out(2'd2, 16'h2200, 1'b1, 1'b1);
    expect_out(2'd0, 16'h2001, 1'b1, 1'b1);
    expect_out(2'd2, 16'h2201, 1'b1, 1'b1);
    drive();
    for (int c = 0; c < 6; c++) begin
      sample();
      chk("t2_ready1", 32'(rdy[1]), 32'd0);
      advance();
    end
    src_q[1].delete();
    drive();
    drain();

    // keep=0,last=0 dropped at once; keep=0,last=1 forwarded
    put(0, 4'd2, 16'h0DD0, 1'b0, 1'b0);
    put(0, 4'd2, 16'h0E01, 1'b0, 1'b1);
    expect_out(2'd0, 16'h0E01, 1'b0, 1'b1);
    drive();
    sample();
    chk("t3_drop_ready", 32'(rdy), 32'h1);
    advance();
    sample();
    chk("t3_fwd_ready", 32'(rdy), 32'h1);
    advance();
    drain();

    // five-cycle output stall; ptr is 1 here
    out_ready = 1'b0;
    put(1, 4'd2, 16'h4100, 1'b1, 1'b1);
    put(2, 4'd2, 16'h4200, 1'b1, 1'b1);
    put(3, 4'd2, 16'h4300, 1'b1, 1'b1);
    expect_out(2'd1, 16'h4100, 1'b1, 1'b1);
    expect_out(2'd2, 16'h4200, 1'b1, 1'b1);
    expect_out(2'd3, 16'h4300, 1'b1, 1'b1);
    drive();
    sample();
    chk("t4_first_grant", 32'(rdy), 32'h2);
    advance();
    put(0, 4'd2, 16'h4DDD, 1'b0, 1'b0);
    drive();
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("t4_stall_ready", 32'(rdy), (c == 0) ? 32'h1 : 32'h0);
      chk("t4_stall_valid", 32'(o0_valid), 32'd1);
      chk("t4_stall_data",  32'(o0_data),  32'h4100);
      advance();
    end
    out_ready = 1'b1;
    sample();
    chk("t4_release_grant", 32'(rdy), 32'h4);
    advance();
    drain();

    // 3-element packet on input0 against input1, per-element arbitration
    for (int k = 0; k < 3; k++) begin
      put(0, 4'd2, 16'h5000 + 16'(k), 1'b1, (k == 2));
      put(1, 4'd2, 16'h5100 + 16'(k), 1'b1, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      expect_out(2'd0, 16'h5000 + 16'(k), 1'b1, (k == 2));
      expect_out(2'd1, 16'h5100 + 16'(k), 1'b1, 1'b1);
    end
    drive();
    drain();

    // switch to the packet-locking instance
    rst0 = 1'b1;
    sel  = 1'b1;
    rst1 = 1'b0;
    sample();
    chk("rst1_valid", 32'(o1_valid), 32'd0);
    chk("rst1_src",   32'(o1_src),   32'd0);
    chk("rst1_data",  32'(o1_data),  32'd0);
    chk("rst1_last",  32'(o1_last),  32'd0);
    advance();

    for (int k = 0; k < 3; k++) begin
      put(0, 4'd2, 16'h5000 + 16'(k), 1'b1, (k == 2));
      put(1, 4'd2, 16'h5100 + 16'(k), 1'b1, 1'b1);
    end
    for (int k = 0; k < 3; k++) expect_out(2'd0, 16'h5000 + 16'(k), 1'b1, (k == 2));
    for (int k = 0; k < 3; k++) expect_out(2'd1, 16'h5100 + 16'(k), 1'b1, 1'b1);
    drive();
    drain();

    // reset while locked on input2 with a held element
    out_ready = 1'b0;
    put(2, 4'd2, 16'h6200, 1'b1, 1'b0);
    drive();
    sample();
    chk("t6_lock_grant", 32'(rdy), 32'h4);
    advance();
    put(1, 4'd2, 16'h6100, 1'b1, 1'b1);
    put(3, 4'd2, 16'h6300, 1'b1, 1'b1);
    drive();
    rst1 = 1'b1;
    sample();
    chk("t6_stall_ready", 32'(rdy), 32'h0);
    advance();
    rst1 = 1'b0;
    expect_out(2'd1, 16'h6100, 1'b1, 1'b1);
    expect_out(2'd3, 16'h6300, 1'b1, 1'b1);
    sample();
    chk("t6_post_rst_valid", 32'(o1_valid), 32'd0);
    chk("t6_post_rst_src",   32'(o1_src),   32'd0);
    chk("t6_post_rst_grant", 32'(rdy),      32'h2);
    advance();
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
